mmul_in_loader: RTL and testbench
=================================

Name: mmul_in_loader

Overview:
- Upstream feeder for the 2x2 fixed-point matrix multiplier.
- Accepts a byte stream holding matrices A and B, each cell 16-bit Q8.8 (8-bit integer, 8-bit fraction), and buffers it in two ping-pong banks.
- Delivers each frame over the multiplier's two-phase 8-bit port handshake: integer bytes on in_rdy1/read_in1, then fraction bytes on in_rdy2/read_in2.
- A second frame can be loaded while the first is being delivered.

Parameters:
- N, 2, matrix dimension; fixed, other values unsupported.
- FRAME_BYTES, 16, bytes per frame (2 matrices x N*N cells x 2 bytes); derived, not to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts byte this cycle.
- abort  in  1  synchronous clear of banks and delivery FSM.
- read_in1  in  1  multiplier acknowledged integer bytes.
- read_in2  in  1  multiplier acknowledged fraction bytes.
- in_rdy1  out  1  integer bytes valid on cell ports.
- in_rdy2  out  1  fraction bytes valid on cell ports.
- A11, A12, A21, A22, B11, B12, B21, B22  out  8 each  cell bytes (integer or fraction, per phase).
- busy  out  1  delivery FSM not in D_IDLE.
- frame_cnt  out  8  frames fully delivered, wraps 255->0.

Behaviour:
- Stream order: A11i, A11f, A12i, A12f, A21i, A21f, A22i, A22f, B11i, B11f, ..., B22f (i = integer byte, f = fraction byte).
- Byte transfer occurs on a rising edge when s_valid and s_ready are both 1.
- Storage: two banks of 16 bytes, bank_full[1:0], wr_bank pointer, 4-bit wr_idx, rd_bank pointer.
- s_ready = !bank_full[wr_bank], combinational from registers; forced 0 while rst is low.
- Accepting byte index 15 sets bank_full[wr_bank], toggles wr_bank and wraps wr_idx to 0. When both banks are full, s_ready = 0.
- Delivery FSM states: D_IDLE, D_INT, D_GAP, D_DEC, D_DONE. All outputs are registered.
- D_IDLE:
  - If bank_full[rd_bank], go to D_INT.
  - in_rdy1 = in_rdy2 = 0; cell ports = 0.
- D_INT:
  - in_rdy1 = 1; cell ports = integer bytes of rd_bank.
  - Hold until read_in1 = 1 is sampled, then go to D_GAP.
- D_GAP:
  - One cycle with in_rdy1 = 0 and in_rdy2 = 0; then go to D_DEC.
- D_DEC:
  - in_rdy2 = 1; cell ports = fraction bytes of rd_bank.
  - Hold until read_in2 = 1 is sampled, then go to D_DONE.
  - read_in1 is ignored outside D_INT.
- D_DONE:
  - in_rdy2 = 0, ports = 0.
  - Clear bank_full[rd_bank], toggle rd_bank, increment frame_cnt; then go to D_IDLE.
- Latency: in_rdy1 goes high one cycle after the edge that sets bank_full for the bank being delivered. Minimum frame delivery time is 4 cycles plus acknowledge waits.
- Simultaneous events:
  - Fill of one bank and release of the other in the same cycle both take effect.
  - A bank released in D_DONE is writable from the next cycle.
- Acknowledge handling: read_in1/read_in2 are level-sensitive and only sampled in their own wait state. A level held high from a previous frame acknowledges immediately; that is legal.
- abort = 1 at a rising edge:
  - Clears bank_full, wr_idx, wr_bank, rd_bank; FSM goes to D_IDLE; in_rdy1/in_rdy2 = 0; ports = 0.
  - frame_cnt is unchanged; any stream byte presented in that cycle is not accepted.
- Reset (rst low, any time, including mid-frame): all of the above cleared, and additionally frame_cnt = 0, busy = 0, s_ready = 0. Operation resumes on the first edge after rst rises.
- No arithmetic on data; bytes pass through unmodified.

Test Plan:
- Single frame:
  - Stream A = {0x0180, 0x0200, 0x0040, 0xFF00}, B = {0x0100, 0x0000, 0x0000, 0x0100}; read_in1 returned after 3 cycles, read_in2 after 2.
  - Required in D_INT: A11=01, A12=02, A21=00, A22=FF, B11=01, B22=01.
  - Required in D_DEC: A11=80, A21=40, others 00.
  - frame_cnt = 1.
- Ping-pong backpressure:
  - Stream 3 frames back-to-back with acks withheld.
  - s_ready falls after byte 31, stays 0 until D_DONE of frame 1, then byte 32 is accepted.
  - Frames are delivered in order.
- Phase gap:
  - read_in1 and read_in2 tied high.
  - Required sequence: in_rdy1 for 1 cycle, one cycle with both low, in_rdy2 for 1 cycle. Never both high together.
- Stream stalls:
  - s_valid toggled randomly during loading; byte order is preserved; in_rdy1 does not rise before byte 15 is accepted.
- Abort mid-D_DEC:
  - in_rdy2 = 0 next cycle, banks empty, frame_cnt unchanged.
  - A fresh frame then delivers correctly.
- Reset mid-load:
  - rst low after byte 7: s_ready = 0 and all outputs 0 immediately (asynchronous), frame_cnt = 0.
  - After release, a new 16-byte frame delivers correctly.

Source files
------------

// File: rtl/mmul_in_loader.sv
// mmul_in_loader: ping-pong buffer that turns a byte stream into 2x2 Q8.8 frames
// and hands them to the multiplier as an integer phase followed by a fraction phase.
module mmul_in_loader #(
  parameter int N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       abort,
  input  logic       read_in1,
  input  logic       read_in2,
  output logic       in_rdy1,
  output logic       in_rdy2,
  output logic [7:0] A11,
  output logic [7:0] A12,
  output logic [7:0] A21,
  output logic [7:0] A22,
  output logic [7:0] B11,
  output logic [7:0] B12,
  output logic [7:0] B21,
  output logic [7:0] B22,
  output logic       busy,
  output logic [7:0] frame_cnt
);
  localparam int FRAME_BYTES = 4 * N * N;
  localparam int CELLS = 2 * N * N;
  localparam int IW = $clog2(FRAME_BYTES);
  typedef enum logic [2:0] {D_IDLE, D_INT, D_GAP, D_DEC, D_DONE} state_e;
  state_e state_q, state_d;
  logic [8*FRAME_BYTES-1:0] mem_q [2];
  logic [8*FRAME_BYTES-1:0] rd_data;
  logic [1:0] bank_full_q, bank_full_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic in_rdy1_q, in_rdy1_d, in_rdy2_q, in_rdy2_d, busy_q, busy_d;
  logic [8*CELLS-1:0] cells_q, cells_d;
  logic accept, last, rel;
  always_comb begin
    s_ready = rst && !bank_full_q[wr_bank_q];
    accept = s_valid && s_ready && !abort;
    last = wr_idx_q == IW'(FRAME_BYTES - 1);
    rel = state_q == D_DONE && !abort;
    state_d = abort ? D_IDLE :
              state_q == D_IDLE ? (bank_full_q[rd_bank_q] ? D_INT : D_IDLE) :
              state_q == D_INT  ? (read_in1 ? D_GAP : D_INT) :
              state_q == D_GAP  ? D_DEC :
              state_q == D_DEC  ? (read_in2 ? D_DONE : D_DEC) : D_IDLE;
    wr_idx_d = abort ? '0 : wr_idx_q + IW'(accept);
    wr_bank_d = !abort && (wr_bank_q ^ (accept && last));
    rd_bank_d = !abort && (rd_bank_q ^ rel);
    bank_full_d = bank_full_q;
    if (rel) bank_full_d[rd_bank_q] = 1'b0;
    if (accept && last) bank_full_d[wr_bank_q] = 1'b1;
    if (abort) bank_full_d = '0;
    frame_cnt_d = frame_cnt_q + 8'(rel);
    in_rdy1_d = state_d == D_INT;
    in_rdy2_d = state_d == D_DEC;
    busy_d = state_d != D_IDLE;
    rd_data = mem_q[rd_bank_q];
    // cell k occupies stream bytes 2k (integer) and 2k+1 (fraction)
    cells_d = '0;
    for (int k = 0; k < CELLS; k++)
      cells_d[8*k +: 8] = in_rdy1_d ? rd_data[16*k +: 8] : in_rdy2_d ? rd_data[16*k+8 +: 8] : 8'h00;
  end
  always_ff @(posedge clk)
    if (accept) mem_q[wr_bank_q][8*wr_idx_q +: 8] <= s_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= D_IDLE;
      bank_full_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q <= '0;
      frame_cnt_q <= '0;
      in_rdy1_q <= 1'b0;
      in_rdy2_q <= 1'b0;
      busy_q <= 1'b0;
      cells_q <= '0;
    end else begin
      state_q <= state_d;
      bank_full_q <= bank_full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q <= wr_idx_d;
      frame_cnt_q <= frame_cnt_d;
      in_rdy1_q <= in_rdy1_d;
      in_rdy2_q <= in_rdy2_d;
      busy_q <= busy_d;
      cells_q <= cells_d;
    end
  assign in_rdy1 = in_rdy1_q;
  assign in_rdy2 = in_rdy2_q;
  assign busy = busy_q;
  assign frame_cnt = frame_cnt_q;
  assign {B22, B21, B12, B11, A22, A21, A12, A11} = cells_q;
endmodule

// File: tb/tb_mmul_in_loader.sv
// tb_mmul_in_loader: random and directed frames against a frame-queue model of the loader
module tb_mmul_in_loader;
  logic clk = 0, rst = 0, s_valid = 0, abort = 0, read_in1 = 0, read_in2 = 0;
  logic [7:0] s_data = 0;
  logic s_ready, in_rdy1, in_rdy2, busy;
  logic [7:0] A11, A12, A21, A22, B11, B12, B21, B22, frame_cnt;
  logic [63:0] ports;
  int n_cmp = 0, n_err = 0, bytes_acc = 0;
  int ack_mode = 0, d1 = 1, d2 = 1, c1 = 0, c2 = 0;
  logic [127:0] fq [$];
  logic [7:0] exp_cnt = 0;
  always #5 clk = ~clk;
  assign ports = {A11, A12, A21, A22, B11, B12, B21, B22};
  mmul_in_loader dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .abort(abort), .read_in1(read_in1), .read_in2(read_in2),
    .in_rdy1(in_rdy1), .in_rdy2(in_rdy2),
    .A11(A11), .A12(A12), .A21(A21), .A22(A22), .B11(B11), .B12(B12), .B21(B21), .B22(B22),
    .busy(busy), .frame_cnt(frame_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // stream byte i sits at f[8i+:8]; cell k has integer byte 2k and fraction byte 2k+1
  function automatic logic [63:0] frame_face(input logic [127:0] f, input logic frac);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[63-8*k -: 8] = f[16*k + (frac ? 8 : 0) +: 8];
    return r;
  endfunction
  function automatic logic [127:0] rnd_frame();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      c1 = 0; c2 = 0; read_in1 = 0; read_in2 = 0; exp_cnt = 0;
      fq.delete();
    end else begin
      chk("rdy_overlap", {63'd0, in_rdy1 & in_rdy2}, 0);
      c1 = in_rdy1 ? c1 + 1 : 0;
      c2 = in_rdy2 ? c2 + 1 : 0;
      if (in_rdy1 || in_rdy2) begin
        if (fq.size() == 0) chk("rdy_no_frame", {62'd0, in_rdy1, in_rdy2}, 0);
        else if (in_rdy1) chk("int_bytes", ports, frame_face(fq[0], 1'b0));
        else chk("frac_bytes", ports, frame_face(fq[0], 1'b1));
      end else chk("idle_ports", ports, 0);
      read_in1 = ack_mode == 1 || ack_mode == 3 || (ack_mode == 2 && in_rdy1 && c1 >= d1);
      read_in2 = ack_mode == 1 || (ack_mode == 2 && in_rdy2 && c2 >= d2);
      if (in_rdy2 && read_in2 && fq.size() > 0) begin
        void'(fq.pop_front());
        exp_cnt++;
      end
    end
  end
  task automatic send(input logic [7:0] b);
    int t = 0;
    s_data = b;
    s_valid = 1;
    while (!s_ready && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) chk("s_ready_timeout", {63'd0, s_ready}, 1);
    @(negedge clk);
    s_valid = 0;
    bytes_acc++;
  endtask
  task automatic send_frame(input logic [127:0] f, input int stall, input logic chk_early);
    for (int i = 0; i < 16; i++) begin
      if (stall > 0 && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, stall)) @(negedge clk);
      if (chk_early) chk("early_rdy", {63'd0, in_rdy1}, 0);
      send(f[8*i +: 8]);
    end
    fq.push_back(f);
  endtask
  task automatic lat_chk();
    chk("lat_lo", {63'd0, in_rdy1}, 0);
    @(negedge clk);
    chk("lat_hi", {63'd0, in_rdy1}, 1);
  endtask
  task automatic wait_idle();
    int t = 0;
    while ((busy || fq.size() != 0) && t < 3000) begin @(negedge clk); t++; end
    chk("idle_timeout", {62'd0, busy, fq.size() != 0}, 0);
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, {63'd0, s_ready}, 0);
    chk({tag, "_rdy"}, {62'd0, in_rdy1, in_rdy2}, 0);
    chk({tag, "_busy"}, {63'd0, busy}, 0);
    chk({tag, "_ports"}, ports, 0);
    chk({tag, "_cnt"}, {56'd0, frame_cnt}, 0);
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    logic [7:0] base;
    int t;
    #2;
    chk_reset_outputs("por");
    @(negedge clk); rst = 1;
    @(negedge clk);
    chk("s_ready_after_rst", {63'd0, s_ready}, 1);
    // single directed frame
    ack_mode = 2; d1 = 3; d2 = 2;
    send_frame(128'h0001_0000_0000_0001_00FF_4000_0002_8001, 0, 1);
    lat_chk();
    chk("t1_int", ports, 64'h0102_00FF_0100_0001);
    for (t = 0; t < 50 && !in_rdy2; t++) @(negedge clk);
    chk("t1_dec_seen", {63'd0, in_rdy2}, 1);
    chk("t1_dec", ports, 64'h8000_4000_0000_0000);
    wait_idle();
    chk("t1_cnt", {56'd0, frame_cnt}, 1);
    // phase gap with acknowledges tied high
    ack_mode = 1;
    send_frame(rnd_frame(), 0, 1);
    chk("gap0", {62'd0, in_rdy1, in_rdy2}, 2'b00);
    @(negedge clk); chk("gap1", {62'd0, in_rdy1, in_rdy2}, 2'b10);
    @(negedge clk); chk("gap2", {62'd0, in_rdy1, in_rdy2}, 2'b00);
    chk("gap2_busy", {63'd0, busy}, 1);
    @(negedge clk); chk("gap3", {62'd0, in_rdy1, in_rdy2}, 2'b01);
    @(negedge clk); chk("gap4", {62'd0, in_rdy1, in_rdy2}, 2'b00);
    chk("gap4_busy", {63'd0, busy}, 1);
    @(negedge clk); chk("gap5_busy", {63'd0, busy}, 0);
    chk("gap_cnt", {56'd0, frame_cnt}, 2);
    // stalled stream, one frame at a time
    ack_mode = 2;
    repeat (4) begin
      d1 = $urandom_range(1, 4); d2 = $urandom_range(1, 4);
      send_frame(rnd_frame(), 3, 1);
      lat_chk();
      wait_idle();
    end
    chk("stall_cnt", {56'd0, frame_cnt}, {56'd0, exp_cnt});
    // back-to-back random burst with varied acknowledge delays
    base = exp_cnt;
    repeat (20) begin
      d1 = $urandom_range(1, 12); d2 = $urandom_range(1, 12);
      send_frame(rnd_frame(), 2, 0);
    end
    wait_idle();
    chk("burst_cnt", {56'd0, frame_cnt}, {56'd0, base + 8'd20});
    // ping-pong backpressure
    ack_mode = 0; bytes_acc = 0; base = exp_cnt;
    fork
      repeat (3) send_frame(rnd_frame(), 0, 0);
      begin
        for (t = 0; t < 500 && bytes_acc < 32; t++) @(negedge clk);
        chk("bp_full", {63'd0, s_ready}, 0);
        chk("bp_hold_rdy", {63'd0, in_rdy1}, 1);
        repeat (8) @(negedge clk);
        chk("bp_still_full", {63'd0, s_ready}, 0);
        chk("bp_stuck_bytes", bytes_acc, 32);
        ack_mode = 1;
        for (t = 0; t < 100 && frame_cnt == base; t++) @(negedge clk);
        chk("bp_release", {63'd0, s_ready}, 1);
        chk("bp_b32_wait", bytes_acc, 32);
        @(negedge clk); #1;
        chk("bp_b32_acc", bytes_acc, 33);
      end
    join
    wait_idle();
    chk("bp_cnt", {56'd0, frame_cnt}, {56'd0, base + 8'd3});
    // abort during the fraction phase, with a partial second frame loaded
    ack_mode = 3; base = exp_cnt;
    send_frame(rnd_frame(), 0, 1);
    for (t = 0; t < 50 && !in_rdy2; t++) @(negedge clk);
    chk("ab_dec_seen", {63'd0, in_rdy2}, 1);
    repeat (5) send(8'($urandom));
    abort = 1;
    @(negedge clk);
    abort = 0;
    fq.delete();
    chk("ab_rdy", {62'd0, in_rdy1, in_rdy2}, 0);
    chk("ab_busy", {63'd0, busy}, 0);
    chk("ab_s_ready", {63'd0, s_ready}, 1);
    chk("ab_cnt", {56'd0, frame_cnt}, {56'd0, base});
    ack_mode = 2; d1 = 2; d2 = 1;
    send_frame(rnd_frame(), 0, 1);
    lat_chk();
    wait_idle();
    chk("ab_fresh_cnt", {56'd0, frame_cnt}, {56'd0, base + 8'd1});
    // asynchronous reset after byte 7
    for (int i = 0; i < 8; i++) send(8'($urandom));
    #2 rst = 0;
    #1 chk_reset_outputs("mid");
    @(negedge clk);
    @(negedge clk); rst = 1;
    @(negedge clk);
    chk("mid_resume", {63'd0, s_ready}, 1);
    send_frame(rnd_frame(), 1, 1);
    lat_chk();
    wait_idle();
    chk("mid_fresh_cnt", {56'd0, frame_cnt}, 1);
    // 256 more frames: frame_cnt wraps back to its starting value
    ack_mode = 1; base = exp_cnt;
    repeat (256) send_frame(rnd_frame(), 0, 0);
    wait_idle();
    chk("wrap_cnt", {56'd0, frame_cnt}, {56'd0, base});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
